// File: rtl/accum_block_looper_n_pkg.sv
// ---------------------------------------------------------------------------
// accum_block_looper_n_pkg
// Shared configuration for the accumulation-block looper family: default
// grid dimensionality, work/offset width, stride shift width, broadcast
// fan-out, and the looper FSM state encoding.
// ---------------------------------------------------------------------------
package accum_block_looper_n_pkg;

    localparam int VDIM_DEF     = 2;   // grid dimensions, index VDIM-1 innermost
    localparam int WORK_BW      = 16;  // offset / work width
    localparam int SHAMT_BW_DEF = 4;   // stride shift width (stride = 1 << shamt)
    localparam int N_DST_DEF    = 3;   // broadcast destinations

    // Looper FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/accum_block_looper_n_if.sv
// ---------------------------------------------------------------------------
// accum_block_looper_n_if
// Bundles the looper's descriptor source (src_rdy/src_ack plus the block
// descriptor fields) and the per-point broadcast (dst_rdy/dst_ack plus the
// point fields).
//   master : block dispatcher side / consumers (drives descriptor and acks)
//   slave  : the looper itself
// ---------------------------------------------------------------------------
interface accum_block_looper_n_if
    import accum_block_looper_n_pkg::*;
#(
    parameter int VDIM     = VDIM_DEF,
    parameter int WBW      = WORK_BW,
    parameter int SHAMT_BW = SHAMT_BW_DEF,
    parameter int N_DST    = N_DST_DEF
);
    // Descriptor source
    logic                               src_rdy;
    logic                               src_ack;
    logic [VDIM-1:0][WBW-1:0]           i_bofs;
    logic [VDIM-1:0][SHAMT_BW-1:0]      i_agrid_shamt;
    logic [VDIM-1:0][WBW-1:0]           i_agrid_last;
    logic [VDIM-1:0][WBW-1:0]           i_alocal_last;
    logic [VDIM-1:0][WBW-1:0]           i_aboundary;
    logic [N_DST-1:0]                   i_dst_en;

    // Point broadcast
    logic [N_DST-1:0]                   dst_rdy;
    logic [N_DST-1:0]                   dst_ack;
    logic [VDIM-1:0][WBW-1:0]           o_bofs;
    logic [VDIM-1:0][WBW-1:0]           o_aofs;
    logic [VDIM-1:0][WBW-1:0]           o_alast;
    logic                               o_islast;
    logic                               blkdone_dval;

    modport master (
        output src_rdy, i_bofs, i_agrid_shamt, i_agrid_last, i_alocal_last,
               i_aboundary, i_dst_en, dst_ack,
        input  src_ack, dst_rdy, o_bofs, o_aofs, o_alast, o_islast, blkdone_dval
    );

    modport slave (
        input  src_rdy, i_bofs, i_agrid_shamt, i_agrid_last, i_alocal_last,
               i_aboundary, i_dst_en, dst_ack,
        output src_ack, dst_rdy, o_bofs, o_aofs, o_alast, o_islast, blkdone_dval
    );

endinterface

// File: rtl/accum_block_looper_n_nd_grid_counter.sv
// ---------------------------------------------------------------------------
// nd_grid_counter
// VDIM-dimensional odometer over a power-of-two-strided grid. Holds the
// current grid point, can be reloaded to the origin, and steps to the next
// point with per-dimension wrap. All stepping compares are done one bit
// wider than the offsets so that points near the top of the range neither
// wrap silently nor run past the last legal offset.
// Ports:
//   i_clk, i_rst    clock, asynchronous active-low reset (point -> origin)
//   load_zero_i     reload the point to all-zero (wins over step_i)
//   step_i          advance to the next grid point
//   shamt_i         per-dimension stride shift
//   last_i          per-dimension largest legal offset (inclusive)
//   aofs_o          current grid point (registered)
//   islast_o        current point is the final point of the grid
// ---------------------------------------------------------------------------
module nd_grid_counter
    import accum_block_looper_n_pkg::*;
#(
    parameter int VDIM     = VDIM_DEF,
    parameter int WBW      = WORK_BW,
    parameter int SHAMT_BW = SHAMT_BW_DEF
)(
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          load_zero_i,
    input  logic                          step_i,
    input  logic [VDIM-1:0][SHAMT_BW-1:0] shamt_i,
    input  logic [VDIM-1:0][WBW-1:0]      last_i,
    output logic [VDIM-1:0][WBW-1:0]      aofs_o,
    output logic                          islast_o
);

    localparam logic [WBW:0] ONE_W = {{WBW{1'b0}}, 1'b1};

    logic [VDIM-1:0][WBW-1:0] aofs_q, aofs_d;
    logic [VDIM-1:0][WBW:0]   sum;
    logic [VDIM-1:0]          wrap;

    // Per-dimension candidate next offset and whether it leaves the grid.
    // A shift amount wider than the offset itself can only leave the grid.
    always_comb begin
        for (int d = 0; d < VDIM; d++) begin
            sum[d]  = {1'b0, aofs_q[d]} + (ONE_W << shamt_i[d]);
            wrap[d] = (int'(shamt_i[d]) > WBW) || (sum[d] > {1'b0, last_i[d]});
        end
    end

    // Odometer: innermost dimension always steps; a wrapping dimension
    // resets to zero and carries outward.
    always_comb begin
        logic carry;
        carry  = 1'b1;
        aofs_d = aofs_q;
        if (load_zero_i) begin
            aofs_d = '0;
        end else if (step_i) begin
            for (int d = VDIM - 1; d >= 0; d--) begin
                if (carry) begin
                    if (wrap[d]) begin
                        aofs_d[d] = '0;
                    end else begin
                        aofs_d[d] = sum[d][WBW-1:0];
                        carry     = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            aofs_q <= '0;
        end else begin
            aofs_q <= aofs_d;
        end
    end

    assign aofs_o   = aofs_q;
    assign islast_o = &wrap;

endmodule

// File: rtl/accum_block_looper_n.sv
// ---------------------------------------------------------------------------
// accum_block_looper_n
// Takes one accumulation-block descriptor at a time and walks its grid,
// broadcasting {bofs, aofs, clamped alast} for every grid point to N_DST
// consumers. Each enabled consumer acks a point independently; the point
// retires once every enabled consumer has acked it, and the descriptor is
// acked together with the final point. A block with no enabled consumers
// is acked one cycle after it is offered without producing any point.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-low reset
//   bus (slave)    src_rdy/src_ack + descriptor fields in,
//                  dst_rdy/dst_ack + point fields out, blkdone_dval
// Point fields (o_bofs, o_alast, o_islast) read zero outside a block.
// ---------------------------------------------------------------------------
module accum_block_looper_n
    import accum_block_looper_n_pkg::*;
#(
    parameter int VDIM     = VDIM_DEF,
    parameter int WBW      = WORK_BW,
    parameter int SHAMT_BW = SHAMT_BW_DEF,
    parameter int N_DST    = N_DST_DEF
)(
    input  logic                  i_clk,
    input  logic                  i_rst,
    accum_block_looper_n_if.slave bus
);

    logic [0:0]               state_q, state_d;
    logic [N_DST-1:0]         acked_q, acked_d;
    logic                     empty_q, empty_d;

    logic                     run;
    logic                     no_en;
    logic [N_DST-1:0]         accepted;
    logic                     point_done;
    logic                     grid_islast;
    logic                     load_zero;
    logic                     step;
    logic [VDIM-1:0][WBW-1:0] aofs;
    logic [VDIM-1:0][WBW-1:0] alast;

    // Clamp aofs + local extent to the boundary; the sum keeps its carry so
    // an overflowing sum is still clamped.
    function automatic logic [WBW-1:0] clamp_last(
        input logic [WBW-1:0] a,
        input logic [WBW-1:0] loc,
        input logic [WBW-1:0] bnd
    );
        logic [WBW:0] s;
        s = {1'b0, a} + {1'b0, loc};
        return (s > {1'b0, bnd}) ? bnd : s[WBW-1:0];
    endfunction

    nd_grid_counter #(
        .VDIM     (VDIM),
        .WBW      (WBW),
        .SHAMT_BW (SHAMT_BW)
    ) u_grid (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .load_zero_i (load_zero),
        .step_i      (step),
        .shamt_i     (bus.i_agrid_shamt),
        .last_i      (bus.i_agrid_last),
        .aofs_o      (aofs),
        .islast_o    (grid_islast)
    );

    assign run      = (state_q == ST_RUN);
    assign no_en    = (bus.i_dst_en == '0);
    assign accepted = bus.dst_ack & bus.dst_rdy;

    // A point retires in the cycle its last outstanding ack arrives.
    assign point_done = run && (((acked_q | accepted) & bus.i_dst_en) == bus.i_dst_en);

    assign bus.dst_rdy      = run ? (bus.i_dst_en & ~acked_q) : '0;
    assign bus.src_ack      = bus.src_rdy & ((point_done & grid_islast) | empty_q);
    assign bus.blkdone_dval = bus.src_ack;

    always_comb begin
        for (int d = 0; d < VDIM; d++) begin
            alast[d] = clamp_last(aofs[d], bus.i_alocal_last[d], bus.i_aboundary[d]);
        end
    end

    assign bus.o_aofs   = aofs;
    assign bus.o_bofs   = run ? bus.i_bofs : '0;
    assign bus.o_alast  = run ? alast : '0;
    assign bus.o_islast = run & grid_islast;

    always_comb begin
        state_d   = state_q;
        acked_d   = acked_q;
        empty_d   = 1'b0;
        load_zero = 1'b0;
        step      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // empty_q blocks re-capturing the descriptor in its own ack cycle
                if (bus.src_rdy && !empty_q) begin
                    if (no_en) begin
                        empty_d = 1'b1;
                    end else begin
                        state_d   = ST_RUN;
                        load_zero = 1'b1;
                        acked_d   = '0;
                    end
                end
            end
            ST_RUN: begin
                if (point_done) begin
                    acked_d = '0;
                    if (grid_islast) begin
                        state_d = ST_IDLE;
                    end else begin
                        step = 1'b1;
                    end
                end else begin
                    acked_d = acked_q | accepted;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
            acked_q <= '0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acked_q <= acked_d;
            empty_q <= empty_d;
        end
    end

endmodule
